// File: rtl/arb_request_sequencer.sv
// Per-channel 4-phase request/grant sequencer in front of the async round-robin arbiter.
// Optional macro GRANT_ONEHOT_CHECK_EN builds the sticky grant-overlap checker on grant_err_o.
module arb_request_sequencer #(
    parameter int unsigned REQUESTORS  = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_W      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REQUESTORS-1:0] job_valid_i,
    input  logic [HOLD_W-1:0]     hold_cycles_i,
    input  logic [REQUESTORS-1:0] grant_i,
    output logic [REQUESTORS-1:0] request_o,
    output logic [REQUESTORS-1:0] busy_o,
    output logic [REQUESTORS-1:0] job_done_o,
    output logic                  grant_err_o
);

    localparam int unsigned LAST_STAGE = SYNC_STAGES - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_OWN  = 2'd2,
        S_REL  = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0][REQUESTORS-1:0] sync_q;
    logic [REQUESTORS-1:0]                  gsync;
    state_e                                 state_q [REQUESTORS];
    logic [HOLD_W-1:0]                      cnt_q   [REQUESTORS];
    logic [REQUESTORS-1:0]                  request_q;
    logic [REQUESTORS-1:0]                  busy_q;
    logic [REQUESTORS-1:0]                  job_done_q;

    // Grant crosses from the arbiter's async domain through a plain flop chain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], grant_i};
        end
    end

    assign gsync = sync_q[LAST_STAGE];

    // Independent handshake FSM per channel; all outputs come straight from flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < REQUESTORS; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end
            request_q  <= '0;
            busy_q     <= '0;
            job_done_q <= '0;
        end else begin
            job_done_q <= '0;
            for (int i = 0; i < REQUESTORS; i++) begin
                unique case (state_q[i])
                    S_IDLE: begin
                        if (job_valid_i[i]) begin
                            state_q[i]   <= S_REQ;
                            cnt_q[i]     <= hold_cycles_i;
                            request_q[i] <= 1'b1;
                            busy_q[i]    <= 1'b1;
                        end
                    end
                    S_REQ: begin
                        if (gsync[i]) begin
                            state_q[i] <= S_OWN;
                        end
                    end
                    S_OWN: begin
                        if (cnt_q[i] == '0) begin
                            state_q[i]   <= S_REL;
                            request_q[i] <= 1'b0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] - HOLD_W'(1);
                        end
                    end
                    S_REL: begin
                        if (!gsync[i]) begin
                            state_q[i]    <= S_IDLE;
                            busy_q[i]     <= 1'b0;
                            job_done_q[i] <= 1'b1;
                        end
                    end
                    default: state_q[i] <= S_IDLE;
                endcase
            end
        end
    end

    assign request_o  = request_q;
    assign busy_o     = busy_q;
    assign job_done_o = job_done_q;

`ifdef GRANT_ONEHOT_CHECK_EN
    logic [REQUESTORS-1:0] idle_c;
    logic                  multi_c;
    logic                  grant_err_q;

    always_comb begin
        idle_c = '0;
        for (int i = 0; i < REQUESTORS; i++) begin
            idle_c[i] = (state_q[i] == S_IDLE);
        end
    end

    // More than one bit set: clearing the lowest set bit leaves something behind.
    assign multi_c = |(gsync & (gsync - REQUESTORS'(1)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant_err_q <= 1'b0;
        end else if (multi_c || |(gsync & idle_c)) begin
            grant_err_q <= 1'b1;
        end
    end

    assign grant_err_o = grant_err_q;
`else
    assign grant_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_arb_request_sequencer.sv
// Randomised scoreboard bench for arb_request_sequencer with a lowest-index-first arbiter model.
module tb_arb_request_sequencer;

    localparam int unsigned R  = 8;
    localparam int unsigned SS = 2;
    localparam int unsigned HW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [R-1:0]  job_valid;
    logic [HW-1:0] hold;
    logic [R-1:0]  grant;
    logic [R-1:0]  request;
    logic [R-1:0]  busy;
    logic [R-1:0]  job_done;
    logic          grant_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    arb_request_sequencer #(
        .REQUESTORS (R),
        .SYNC_STAGES(SS),
        .HOLD_W     (HW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .job_valid_i  (job_valid),
        .hold_cycles_i(hold),
        .grant_i      (grant),
        .request_o    (request),
        .busy_o       (busy),
        .job_done_o   (job_done),
        .grant_err_o  (grant_err)
    );

    // Arbiter: grant the lowest-index requester, keep it until its request falls.
    int           arb_owner = -1;
    logic         force_en  = 1'b0;
    logic [R-1:0] force_val = '0;

    always @(request) begin
        if (arb_owner >= 0 && request[arb_owner] !== 1'b1) arb_owner = -1;
        if (arb_owner < 0) begin
            for (int i = R - 1; i >= 0; i--) begin
                if (request[i] === 1'b1) arb_owner = i;
            end
        end
    end

    always @* begin
        if (force_en)           grant = force_val;
        else if (arb_owner >= 0) grant = R'(1) << arb_owner;
        else                    grant = '0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: timestamps from the handshake rules.
    // Grant at edge g -> release at g+hold+4 -> idle/done at release+3 -> next accept +1.
    typedef struct {
        int ch;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n = 0;
    bit   busy_m [R];
    bit   req_m  [R];
    bit   wait_m [R];
    int   hold_m [R];
    int   idle_at[R];
    int   owner_m = -1;
    int   rel_at_m = 0;

    always @(posedge clk) begin
        int pick;
        n = n + 1;
        if (rst === 1'b1) begin
            owner_m = -1;
            for (int i = 0; i < R; i++) begin
                busy_m[i] = 1'b0;
                req_m[i]  = 1'b0;
                wait_m[i] = 1'b0;
            end
            exp_q.delete();
        end else begin
            for (int i = 0; i < R; i++) begin
                if (!busy_m[i] && job_valid[i]) begin
                    busy_m[i] = 1'b1;
                    req_m[i]  = 1'b1;
                    wait_m[i] = 1'b1;
                    hold_m[i] = int'(hold);
                end
            end
            if (owner_m >= 0 && n == rel_at_m) begin
                req_m[owner_m] = 1'b0;
                owner_m = -1;
            end
            for (int i = 0; i < R; i++) begin
                if (busy_m[i] && !req_m[i] && n == idle_at[i]) busy_m[i] = 1'b0;
            end
            if (owner_m < 0) begin
                pick = -1;
                for (int i = R - 1; i >= 0; i--) begin
                    if (wait_m[i]) pick = i;
                end
                if (pick >= 0) begin
                    owner_m       = pick;
                    wait_m[pick]  = 1'b0;
                    rel_at_m      = n + hold_m[pick] + 4;
                    idle_at[pick] = rel_at_m + 3;
                    exp_q.push_back('{ch: pick, cyc: idle_at[pick]});
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the model every cycle, on the falling edge.
    logic [R-1:0] exp_done, exp_req, exp_busy;
    always @(negedge clk) begin
        exp_done = '0;
        while (exp_q.size() > 0 && exp_q[0].cyc <= n) begin
            if (exp_q[0].cyc == n) exp_done[exp_q[0].ch] = 1'b1;
            void'(exp_q.pop_front());
        end
        for (int i = 0; i < R; i++) begin
            exp_req[i]  = req_m[i];
            exp_busy[i] = busy_m[i];
        end
        chk("request", 32'(request), 32'(exp_req));
        chk("busy", 32'(busy), 32'(exp_busy));
        if (exp_done != '0 || job_done != '0) chk("job_done", 32'(job_done), 32'(exp_done));
    end

    int req_cnt, done_cnt, done_pos, done0, done1, rises, min_gap, gap;
    logic prev_req;

    initial begin
        rst = 1'b1; job_valid = '1; hold = '0;
        repeat (3) @(negedge clk);
        chk("t1_request", 32'(request), 32'h0);
        chk("t1_busy", 32'(busy), 32'h0);
        chk("t1_done", 32'(job_done), 32'h0);
        chk("t1_err", 32'(grant_err), 32'h0);
        rst = 1'b0; job_valid = '0;
        repeat (2) @(negedge clk);

        // Single tenure, hold=3.
        job_valid = 8'h01; hold = 4'd3;
        req_cnt = 0; done_cnt = 0; done_pos = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            job_valid = '0; hold = 4'd9;
            if (request[0]) req_cnt++;
            if (job_done[0]) begin done_cnt++; done_pos = k; end
        end
        chk("t2_req_cycles", 32'(req_cnt), 32'd7);
        chk("t2_done_count", 32'(done_cnt), 32'd1);
        chk("t2_done_pos", 32'(done_pos), 32'd10);

        // Contention between ch0 and ch1.
        job_valid = 8'h03; hold = 4'd0;
        done0 = -1; done1 = -1; done_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            job_valid = '0;
            if (job_done[0]) begin done0 = k; done_cnt++; end
            if (job_done[1]) begin done1 = k; done_cnt++; end
        end
        chk("t3_done_count", 32'(done_cnt), 32'd2);
        chk("t3_order", 32'(done0 < done1), 32'd1);

        // Back-to-back tenures on ch2.
        job_valid = 8'h04; hold = 4'd1;
        rises = 0; done_cnt = 0; min_gap = 1000; gap = 0; prev_req = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (k == 35) job_valid = '0;
            if (request[2] && !prev_req) begin
                rises++;
                if (rises > 1 && gap < min_gap) min_gap = gap;
            end
            gap = request[2] ? 0 : gap + 1;
            if (job_done[2]) done_cnt++;
            prev_req = request[2];
        end
        chk("t4_multi_tenure", 32'(rises >= 2), 32'd1);
        chk("t4_done_per_tenure", 32'(done_cnt), 32'(rises));
        chk("t4_gap", 32'(min_gap >= 1), 32'd1);

        // Reset while ch3 owns.
        job_valid = 8'h08; hold = 4'd10;
        @(negedge clk);
        job_valid = '0;
        repeat (6) @(negedge clk);
        chk("t5_owning", 32'(request[3]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_req_drop", 32'(request), 32'h0);
        rst = 1'b0;
        job_valid = 8'h08; hold = 4'd2;
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            job_valid = '0;
            if (job_done[3]) done_cnt++;
        end
        chk("t5_after_reset", 32'(done_cnt), 32'd1);

        // Overlapping grant forced while every channel is idle.
        force_val = 8'h21; force_en = 1'b1;
        repeat (3) @(negedge clk);
        force_en = 1'b0;
        repeat (4) @(negedge clk);
`ifdef GRANT_ONEHOT_CHECK_EN
        chk("t6_err_set", 32'(grant_err), 32'd1);
        repeat (3) @(negedge clk);
        chk("t6_err_sticky", 32'(grant_err), 32'd1);
`else
        chk("t6_err_tied", 32'(grant_err), 32'd0);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_err_reset", 32'(grant_err), 32'd0);

        // Random traffic, including hold edge values and rare resets.
        for (int k = 0; k < 500; k++) begin
            job_valid = R'($urandom & $urandom & $urandom);
            hold      = HW'($urandom_range(0, 15));
            rst       = ($urandom_range(0, 149) == 0);
            @(negedge clk);
        end
        rst = 1'b0; job_valid = '0;
        repeat (250) @(negedge clk);
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_idle", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
